spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 51 +++++
 rtl/spi_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Bus bundle between two word requesters, the spi_arbiter and one SPI engine.
// The arbiter connects through the master modport; the environment (requesters plus engine) uses slave.
interface spi_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_tx;
    logic        req1_tx;
    logic [15:0] req0_data;
    logic [15:0] req1_data;
    logic [3:0]  req0_len;
    logic [3:0]  req1_len;
    logic [3:0]  req0_cfg;
    logic [3:0]  req1_cfg;
    logic        req0_accept;
    logic        req1_accept;
    logic        req0_done;
    logic        req1_done;
    logic [15:0] req0_rx_data;
    logic [15:0] req1_rx_data;
    logic        spi_tx_start;
    logic        spi_rx_start;
    logic        spi_rx_ack;
    logic [15:0] spi_tx_data;
    logic [3:0]  spi_word_length;
    logic [1:0]  spi_ss_select;
    logic        spi_lsb_first;
    logic        spi_rising_edge;
    logic        spi_tx_ready;
    logic        spi_rx_ready;
    logic        spi_rx_data_ready;
    logic [15:0] spi_rx_data;
    logic        busy;

    modport master (
        input  req0_valid, req1_valid, req0_tx, req1_tx, req0_data, req1_data,
               req0_len, req1_len, req0_cfg, req1_cfg,
               spi_tx_ready, spi_rx_ready, spi_rx_data_ready, spi_rx_data,
        output req0_accept, req1_accept, req0_done, req1_done, req0_rx_data, req1_rx_data,
               spi_tx_start, spi_rx_start, spi_rx_ack, spi_tx_data, spi_word_length,
               spi_ss_select, spi_lsb_first, spi_rising_edge, busy
    );

    modport slave (
        output req0_valid, req1_valid, req0_tx, req1_tx, req0_data, req1_data,
               req0_len, req1_len, req0_cfg, req1_cfg,
               spi_tx_ready, spi_rx_ready, spi_rx_data_ready, spi_rx_data,
        input  req0_accept, req1_accept, req0_done, req1_done, req0_rx_data, req1_rx_data,
               spi_tx_start, spi_rx_start, spi_rx_ack, spi_tx_data, spi_word_length,
               spi_ss_select, spi_lsb_first, spi_rising_edge, busy
    );
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester arbiter that sequences single-word transfers through one SPI engine.
// SPI_ARB_RR_EN selects round-robin arbitration; when it is undefined, req0 has fixed priority.
module spi_arbiter (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    spi_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_END,
        S_RX_ACK,
        S_WAIT_READY
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic        r_tx;
    logic [15:0] r_tx_data;
    logic [3:0]  r_len;
    logic [1:0]  r_ss;
    logic        r_lsb;
    logic        r_rise;
    logic [15:0] r_rx0;
    logic [15:0] r_rx1;
    logic        r_done0;
    logic        r_done1;

    logic        w_grant1;
    logic        w_select;
    logic        w_accept;
    logic        w_tx_start;
    logic        w_rx_start;
    logic        w_rx_ack;
    logic        w_finish;
    logic        w_capture;

`ifdef SPI_ARB_RR_EN
    logic r_last_grant;

    // On a tie the requester that did not win last time is served.
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_ISSUE) begin
            r_last_grant <= r_owner;
        end
    end
`else
    assign w_grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    // The engine is started only when it reports both directions ready.
    assign w_select = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid)
                      && bus.spi_tx_ready && bus.spi_rx_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tx_start   = 1'b0;
        w_rx_start   = 1'b0;
        w_rx_ack     = 1'b0;
        w_finish     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_select) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_accept     = 1'b1;
                w_tx_start   = r_tx;
                w_rx_start   = !r_tx;
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.spi_tx_ready) begin
                    w_state_next = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (r_tx) begin
                    if (bus.spi_tx_ready) begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else if (bus.spi_rx_data_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RX_ACK;
                end
            end
            S_RX_ACK: begin
                w_rx_ack     = 1'b1;
                w_state_next = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (bus.spi_tx_ready && bus.spi_rx_ready) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Done is registered so it lands in the first IDLE cycle, even if a new winner is chosen there.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_owner   <= 1'b0;
            r_tx      <= 1'b0;
            r_tx_data <= 16'h0000;
            r_len     <= 4'h0;
            r_ss      <= 2'b00;
            r_lsb     <= 1'b0;
            r_rise    <= 1'b0;
            r_rx0     <= 16'h0000;
            r_rx1     <= 16'h0000;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
        end else begin
            r_done0 <= w_finish && !r_owner;
            r_done1 <= w_finish && r_owner;
            if (w_select) begin
                r_owner   <= w_grant1;
                r_tx      <= w_grant1 ? bus.req1_tx   : bus.req0_tx;
                r_tx_data <= w_grant1 ? bus.req1_data : bus.req0_data;
                r_len     <= w_grant1 ? bus.req1_len  : bus.req0_len;
                {r_ss, r_lsb, r_rise} <= w_grant1 ? bus.req1_cfg : bus.req0_cfg;
            end
            if (w_capture) begin
                if (r_owner) begin
                    r_rx1 <= bus.spi_rx_data;
                end else begin
                    r_rx0 <= bus.spi_rx_data;
                end
            end
        end
    end

    assign bus.req0_accept     = w_accept && !r_owner;
    assign bus.req1_accept     = w_accept && r_owner;
    assign bus.req0_done       = r_done0;
    assign bus.req1_done       = r_done1;
    assign bus.req0_rx_data    = r_rx0;
    assign bus.req1_rx_data    = r_rx1;
    assign bus.spi_tx_start    = w_tx_start;
    assign bus.spi_rx_start    = w_rx_start;
    assign bus.spi_rx_ack      = w_rx_ack;
    assign bus.spi_tx_data     = r_tx_data;
    assign bus.spi_word_length = r_len;
    assign bus.spi_ss_select   = r_ss;
    assign bus.spi_lsb_first   = r_lsb;
    assign bus.spi_rising_edge = r_rise;
    assign bus.busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter; engine behaviour is scripted cycle by cycle in each task.
module tb_spi_arbiter;
    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   errors;
    int   n_acc0, n_acc1, n_done0, n_done1, n_txs, n_rxs, n_ack, n_viol;

    spi_arbiter_if bus_if ();

    spi_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse tallies, sampled on the falling edge.
    initial begin
        n_acc0 = 0; n_acc1 = 0; n_done0 = 0; n_done1 = 0;
        n_txs = 0; n_rxs = 0; n_ack = 0; n_viol = 0;
    end
    always @(negedge sys_clk) begin
        if (bus_if.req0_accept) n_acc0++;
        if (bus_if.req1_accept) n_acc1++;
        if (bus_if.req0_done) n_done0++;
        if (bus_if.req1_done) n_done1++;
        if (bus_if.spi_tx_start) n_txs++;
        if (bus_if.spi_rx_start) n_rxs++;
        if (bus_if.spi_rx_ack) n_ack++;
        if ((bus_if.req0_accept || bus_if.req0_done) && (bus_if.req1_accept || bus_if.req1_done)) n_viol++;
        if (bus_if.req0_accept && bus_if.req0_done) n_viol++;
        if (bus_if.req1_accept && bus_if.req1_done) n_viol++;
        if (bus_if.spi_tx_start && bus_if.spi_rx_start) n_viol++;
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
        end
        checks++;
        if ({bus_if.spi_tx_data, bus_if.spi_word_length, bus_if.spi_ss_select,
             bus_if.spi_lsb_first, bus_if.spi_rising_edge} !== 24'h0) begin
            errors++; $display("FAIL reset_cfg: got %h/%h/%h/%b/%b expected all 0", bus_if.spi_tx_data,
                               bus_if.spi_word_length, bus_if.spi_ss_select, bus_if.spi_lsb_first, bus_if.spi_rising_edge);
        end
        checks++;
        if ({bus_if.req0_rx_data, bus_if.req1_rx_data} !== 32'h0) begin
            errors++; $display("FAIL reset_rx_data: got %h %h expected 0 0", bus_if.req0_rx_data, bus_if.req1_rx_data);
        end
        checks++;
        if ({bus_if.req0_accept, bus_if.req1_accept, bus_if.req0_done, bus_if.req1_done,
             bus_if.spi_tx_start, bus_if.spi_rx_start, bus_if.spi_rx_ack} !== 7'b0) begin
            errors++; $display("FAIL reset_pulses: some pulse high, expected none");
        end
        sys_rst_n = 1'b1;
        tick();
        $display("txn reset: done");
    endtask

    task automatic test_tx();
        int s_txs = n_txs;
        int s_d0 = n_done0;
        bus_if.req0_valid = 1'b1; bus_if.req0_tx = 1'b1; bus_if.req0_data = 16'hA5C3;
        bus_if.req0_len = 4'd15; bus_if.req0_cfg = 4'b1001;
        tick();
        checks++;
        if ({bus_if.req0_accept, bus_if.spi_tx_start, bus_if.spi_rx_start} !== 3'b110) begin
            errors++; $display("FAIL tx_issue: got acc=%b txs=%b rxs=%b expected 1 1 0",
                               bus_if.req0_accept, bus_if.spi_tx_start, bus_if.spi_rx_start);
        end
        checks++;
        if ({bus_if.spi_tx_data, bus_if.spi_word_length, bus_if.spi_ss_select,
             bus_if.spi_lsb_first, bus_if.spi_rising_edge} !== {16'hA5C3, 4'd15, 2'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL tx_cfg: got data=%h len=%0d ss=%0d lsb=%b rise=%b expected a5c3 15 2 0 1",
                               bus_if.spi_tx_data, bus_if.spi_word_length, bus_if.spi_ss_select,
                               bus_if.spi_lsb_first, bus_if.spi_rising_edge);
        end
        bus_if.req0_valid = 1'b0; bus_if.req0_data = 16'h0000; bus_if.spi_tx_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus_if.busy !== 1'b1 || n_done0 != s_d0 || bus_if.spi_tx_data !== 16'hA5C3) begin
            errors++; $display("FAIL tx_in_flight: got busy=%b dones=%0d data=%h expected 1 0 a5c3",
                               bus_if.busy, n_done0 - s_d0, bus_if.spi_tx_data);
        end
        bus_if.spi_tx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.req0_done !== 1'b1 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL tx_done: got done=%b busy=%b expected 1 0", bus_if.req0_done, bus_if.busy);
        end
        tick();
        checks++;
        if (n_txs - s_txs != 1 || n_done0 - s_d0 != 1) begin
            errors++; $display("FAIL tx_counts: got starts=%0d dones=%0d expected 1 1", n_txs - s_txs, n_done0 - s_d0);
        end
        $display("txn tx req0 data=a5c3 len=15");
    endtask

    task automatic test_rx();
        int s_ack = n_ack;
        int s_d1 = n_done1;
        bus_if.req1_valid = 1'b1; bus_if.req1_tx = 1'b0; bus_if.req1_data = 16'hFFFF;
        bus_if.req1_len = 4'd7; bus_if.req1_cfg = 4'b0110;
        tick();
        checks++;
        if ({bus_if.req1_accept, bus_if.req0_accept, bus_if.spi_rx_start, bus_if.spi_tx_start} !== 4'b1010) begin
            errors++; $display("FAIL rx_issue: got acc1=%b acc0=%b rxs=%b txs=%b expected 1 0 1 0",
                               bus_if.req1_accept, bus_if.req0_accept, bus_if.spi_rx_start, bus_if.spi_tx_start);
        end
        checks++;
        if ({bus_if.spi_word_length, bus_if.spi_ss_select, bus_if.spi_lsb_first, bus_if.spi_rising_edge}
            !== {4'd7, 2'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rx_cfg: got len=%0d ss=%0d lsb=%b rise=%b expected 7 1 1 0",
                               bus_if.spi_word_length, bus_if.spi_ss_select, bus_if.spi_lsb_first, bus_if.spi_rising_edge);
        end
        bus_if.req1_valid = 1'b0; bus_if.spi_tx_ready = 1'b0; bus_if.spi_rx_ready = 1'b0;
        tick();
        tick();
        bus_if.spi_rx_data = 16'h1234; bus_if.spi_rx_data_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.spi_rx_ack !== 1'b1 || bus_if.req1_rx_data !== 16'h1234 || bus_if.req0_rx_data !== 16'h0000) begin
            errors++; $display("FAIL rx_capture: got ack=%b rx1=%h rx0=%h expected 1 1234 0000",
                               bus_if.spi_rx_ack, bus_if.req1_rx_data, bus_if.req0_rx_data);
        end
        bus_if.spi_rx_data_ready = 1'b0; bus_if.spi_rx_data = 16'hDEAD;
        tick();
        checks++;
        if (bus_if.spi_rx_ack !== 1'b0 || bus_if.req1_done !== 1'b0 || bus_if.req1_rx_data !== 16'h1234) begin
            errors++; $display("FAIL rx_wait_ready: got ack=%b done=%b rx1=%h expected 0 0 1234",
                               bus_if.spi_rx_ack, bus_if.req1_done, bus_if.req1_rx_data);
        end
        bus_if.spi_tx_ready = 1'b1; bus_if.spi_rx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.req1_done !== 1'b1 || bus_if.req0_done !== 1'b0) begin
            errors++; $display("FAIL rx_done: got done1=%b done0=%b expected 1 0", bus_if.req1_done, bus_if.req0_done);
        end
        tick();
        checks++;
        if (n_ack - s_ack != 1 || n_done1 - s_d1 != 1) begin
            errors++; $display("FAIL rx_counts: got acks=%0d dones=%0d expected 1 1", n_ack - s_ack, n_done1 - s_d1);
        end
        $display("txn rx req1 data=%h", bus_if.req1_rx_data);
    endtask

    task automatic test_arbitration();
        int order [4];
        int exp_order [4];
        int na = 0;
        int cnt = 0;
        int s_d = n_done0 + n_done1;
`ifdef SPI_ARB_RR_EN
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
        for (int i = 0; i < 4; i++) order[i] = 9;
        bus_if.req0_valid = 1'b1; bus_if.req0_tx = 1'b1; bus_if.req0_data = 16'h1111; bus_if.req0_len = 4'd3;
        bus_if.req1_valid = 1'b1; bus_if.req1_tx = 1'b1; bus_if.req1_data = 16'h2222; bus_if.req1_len = 4'd3;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (na == 4 && !bus_if.busy) break;
            if (bus_if.req0_accept && na < 4) begin order[na] = 0; na++; end
            if (bus_if.req1_accept && na < 4) begin order[na] = 1; na++; end
            if (na == 4) begin bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0; end
            if (bus_if.spi_tx_start) cnt = 3;
            else if (cnt > 0) cnt--;
            bus_if.spi_tx_ready = (cnt == 0);
        end
        checks++;
        if (na != 4 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL arb_timeout: got %0d accepts busy=%b expected 4 0", na, bus_if.busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
                errors++; $display("FAIL arb_order[%0d]: got req%0d expected req%0d", i, order[i], exp_order[i]);
            end
            $display("txn arb word %0d granted req%0d", i, order[i]);
        end
        tick();
        checks++;
        if (n_done0 + n_done1 - s_d != 4) begin
            errors++; $display("FAIL arb_dones: got %0d expected 4", n_done0 + n_done1 - s_d);
        end
    endtask

    task automatic test_ready_gating();
        int s_acc = n_acc0;
        int s_st = n_txs + n_rxs;
        bus_if.spi_tx_ready = 1'b0; bus_if.spi_rx_ready = 1'b1;
        bus_if.req0_valid = 1'b1; bus_if.req0_tx = 1'b1; bus_if.req0_data = 16'h0F0F;
        bus_if.req0_len = 4'd3; bus_if.req0_cfg = 4'b0000;
        repeat (20) tick();
        checks++;
        if (n_acc0 != s_acc || n_txs + n_rxs != s_st || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL gate_hold: got accepts=%0d starts=%0d busy=%b expected 0 0 0",
                               n_acc0 - s_acc, n_txs + n_rxs - s_st, bus_if.busy);
        end
        bus_if.spi_tx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.req0_accept !== 1'b1 || bus_if.spi_tx_start !== 1'b1) begin
            errors++; $display("FAIL gate_release: got acc=%b txs=%b expected 1 1", bus_if.req0_accept, bus_if.spi_tx_start);
        end
        bus_if.req0_valid = 1'b0; bus_if.spi_tx_ready = 1'b0;
        tick();
        tick();
        bus_if.spi_tx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.req0_done !== 1'b1) begin
            errors++; $display("FAIL gate_done: got %b expected 1", bus_if.req0_done);
        end
        tick();
        $display("txn gated tx req0 data=0f0f");
    endtask

    task automatic test_reset_mid();
        int s_d = n_done0 + n_done1;
        int s_st;
        bus_if.req1_valid = 1'b1; bus_if.req1_tx = 1'b0; bus_if.req1_len = 4'hA; bus_if.req1_cfg = 4'b1100;
        tick();
        checks++;
        if (bus_if.req1_accept !== 1'b1 || bus_if.spi_rx_start !== 1'b1) begin
            errors++; $display("FAIL mid_issue: got acc1=%b rxs=%b expected 1 1", bus_if.req1_accept, bus_if.spi_rx_start);
        end
        bus_if.req1_valid = 1'b0; bus_if.spi_tx_ready = 1'b0; bus_if.spi_rx_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.spi_ss_select !== 2'd3) begin
            errors++; $display("FAIL mid_wait_end: got busy=%b ss=%0d expected 1 3", bus_if.busy, bus_if.spi_ss_select);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.spi_ss_select !== 2'd0 || bus_if.spi_word_length !== 4'd0) begin
            errors++; $display("FAIL mid_async_reset: got busy=%b ss=%0d len=%0d expected 0 0 0",
                               bus_if.busy, bus_if.spi_ss_select, bus_if.spi_word_length);
        end
        checks++;
        if (bus_if.req1_rx_data !== 16'h0000) begin
            errors++; $display("FAIL mid_rx_clear: got %h expected 0000", bus_if.req1_rx_data);
        end
        tick();
        sys_rst_n = 1'b1;
        s_st = n_txs + n_rxs;
        bus_if.req0_valid = 1'b1; bus_if.req0_tx = 1'b1; bus_if.req0_data = 16'h5A5A;
        bus_if.req0_len = 4'd15; bus_if.req0_cfg = 4'b0001;
        repeat (5) tick();
        checks++;
        if (n_txs + n_rxs != s_st || n_done0 + n_done1 != s_d || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL mid_no_restart: got starts=%0d dones=%0d busy=%b expected 0 0 0",
                               n_txs + n_rxs - s_st, n_done0 + n_done1 - s_d, bus_if.busy);
        end
        bus_if.spi_tx_ready = 1'b1; bus_if.spi_rx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.spi_tx_start !== 1'b1 || bus_if.req0_accept !== 1'b1 || bus_if.spi_tx_data !== 16'h5A5A) begin
            errors++; $display("FAIL mid_restart: got txs=%b acc=%b data=%h expected 1 1 5a5a",
                               bus_if.spi_tx_start, bus_if.req0_accept, bus_if.spi_tx_data);
        end
        bus_if.req0_valid = 1'b0; bus_if.spi_tx_ready = 1'b0;
        tick();
        tick();
        bus_if.spi_tx_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.req0_done !== 1'b1) begin
            errors++; $display("FAIL mid_done: got %b expected 1", bus_if.req0_done);
        end
        tick();
        $display("txn reset-mid rx req1 aborted, tx req0 data=5a5a");
    endtask

    task automatic test_pulse_exclusive();
        checks++;
        if (n_viol != 0) begin
            errors++; $display("FAIL pulse_exclusive: got %0d coinciding pulses expected 0", n_viol);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sys_rst_n = 1'b0;
        bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
        bus_if.req0_tx = 1'b0; bus_if.req1_tx = 1'b0;
        bus_if.req0_data = 16'h0; bus_if.req1_data = 16'h0;
        bus_if.req0_len = 4'h0; bus_if.req1_len = 4'h0;
        bus_if.req0_cfg = 4'h0; bus_if.req1_cfg = 4'h0;
        bus_if.spi_tx_ready = 1'b1; bus_if.spi_rx_ready = 1'b1;
        bus_if.spi_rx_data_ready = 1'b0; bus_if.spi_rx_data = 16'h0;
        test_reset();
        test_tx();
        test_rx();
        test_arbitration();
        test_ready_gating();
        test_reset_mid();
        test_pulse_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
